// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: frame state encoding and prescale constants shared by the UART receiver
package uart_rx_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int PRESCALE_8   = 8;
    localparam int PRESCALE_16  = 16;
    localparam int PRESCALE_32  = 32;
    localparam int PRESCALE_RST = PRESCALE_8;

    function automatic logic is_legal_prescale(input int p);
        return p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line, checker handshake and frame status signals around the frame controller
interface uart_rx_fsm_if #(
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic                  par_en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stop_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  dat_samp_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stop_chk_en;
    logic                  deser_en;
    logic                  data_valid;
    logic                  busy;

    modport slave (
        input  rx_in, par_en, prescale, strt_glitch, par_err, stop_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stop_chk_en,
               deser_en, data_valid, busy
    );

    modport master (
        output rx_in, par_en, prescale, strt_glitch, par_err, stop_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stop_chk_en,
               deser_en, data_valid, busy
    );
endinterface

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// uart_rx_fsm_edge_bit_counter: oversample edge index and data bit index with bit-end detection
module uart_rx_fsm_edge_bit_counter #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  bit_inc,
    input  logic [PRESCALE_W-1:0] p,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  bit_end,
    output logic                  last_bit
);
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;

    // Edge index wraps at P-1; bit index advances only on data bit ends and clears after the last one
    always_comb begin
        bit_end    = en && edge_cnt_q == p - PRESCALE_W'(1);
        last_bit   = bit_cnt_q == 4'(DATA_W - 1);
        edge_cnt_d = (!en || bit_end) ? '0 : edge_cnt_q + PRESCALE_W'(1);
        bit_cnt_d  = !en ? '0 : !(bit_inc && bit_end) ? bit_cnt_q : last_bit ? '0 : bit_cnt_q + 4'd1;
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receiver frame controller sequencing start, data, parity and stop bits
module uart_rx_fsm
    import uart_rx_fsm_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fsm_if.slave bus
);
    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] p_q, p_d, edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  bit_end, last_bit, pre_chk;
    logic                  strt_chk_en_q, strt_chk_en_d;
    logic                  par_chk_en_q, par_chk_en_d;
    logic                  stop_chk_en_q, stop_chk_en_d;
    logic                  deser_en_q, deser_en_d;
    logic                  data_valid_q, data_valid_d;
    logic                  busy_q, busy_d;

    uart_rx_fsm_edge_bit_counter #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .bit_inc  (state_q == DATA),
        .p        (p_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end),
        .last_bit (last_bit)
    );

    // Next state plus pulses decoded one edge early so the registered pulses land on edge P-2
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE:    if (!bus.rx_in) begin
                         state_d = START;
                         p_d     = bus.prescale;
                     end
            START:   if (bit_end) state_d = bus.strt_glitch ? IDLE : DATA;
            DATA:    if (bit_end && last_bit) state_d = bus.par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = bus.par_err ? IDLE : STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pre_chk       = edge_cnt == p_q - PRESCALE_W'(3);
        strt_chk_en_d = pre_chk && state_q == START;
        deser_en_d    = pre_chk && state_q == DATA;
        par_chk_en_d  = pre_chk && state_q == PARITY;
        stop_chk_en_d = pre_chk && state_q == STOP;
        data_valid_d  = bit_end && state_q == STOP && !bus.stop_err;
        busy_d        = state_d != IDLE;
    end

    // State, latched prescale and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            p_q           <= PRESCALE_W'(PRESCALE_RST);
            strt_chk_en_q <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stop_chk_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            strt_chk_en_q <= strt_chk_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stop_chk_en_q <= stop_chk_en_d;
            deser_en_q    <= deser_en_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.dat_samp_en = busy_q;
    assign bus.busy        = busy_q;
    assign bus.strt_chk_en = strt_chk_en_q;
    assign bus.par_chk_en  = par_chk_en_q;
    assign bus.stop_chk_en = stop_chk_en_q;
    assign bus.deser_en    = deser_en_q;
    assign bus.data_valid  = data_valid_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: randomized frames against a frame-level reference model with a queue-based scoreboard
module tb_uart_rx_fsm;
    import uart_rx_fsm_pkg::*;

    localparam int DATA_W = 8;

    typedef struct {
        int p;
        bit pe;
        int len;
        bit valid;
        int n_deser;
        int n_par;
        int n_stop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fsm_if bus();

    uart_rx_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   valid_cyc[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   stray  = 0;
    bit   in_frame = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Frame outcome from the bit sequence: start, DATA_W data, optional parity, stop
    function automatic exp_t model(input int p, input bit pe, input bit g, input bit perr, input bit serr);
        exp_t m;
        bit   reach_stop;
        int   nb;
        reach_stop = !g && !(pe && perr);
        nb        = g ? 1 : reach_stop ? DATA_W + 2 + int'(pe) : DATA_W + 2;
        m.p       = p;
        m.pe      = pe;
        m.len     = nb * p;
        m.valid   = reach_stop && !serr;
        m.n_deser = g ? 0 : DATA_W;
        m.n_par   = (!g && pe) ? 1 : 0;
        m.n_stop  = reach_stop ? 1 : 0;
        return m;
    endfunction

    // Expected {strt, deser, par, stop} for frame cycle c
    function automatic logic [3:0] exp_pulse(input exp_t m, input int c);
        int b;
        b = c / m.p;
        if (c % m.p != m.p - 2) return 4'b0000;
        if (b == 0) return 4'b1000;
        if (b <= DATA_W) return 4'b0100;
        if (b == DATA_W + 1 && m.pe) return 4'b0010;
        return 4'b0001;
    endfunction

    function automatic int exp_bitcnt(input exp_t m, input int c);
        int b;
        b = c / m.p;
        return (b >= 1 && b <= DATA_W) ? b - 1 : 0;
    endfunction

    // Monitor: pops an expectation when a frame starts, traces it, scores it when busy drops
    initial begin
        exp_t       cur;
        int         c, bad, nd, np, ns;
        bit         bogus;
        logic [3:0] a4;
        string      first_bad;
        c = 0; bad = 0; nd = 0; np = 0; ns = 0; bogus = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && bus.busy) begin
                    in_frame = 1'b1;
                    c = 0; bad = 0; nd = 0; np = 0; ns = 0;
                    first_bad = "";
                    bogus = exp_q.size() == 0;
                    chk("frame_expected", int'(bogus), 0);
                    if (!bogus) cur = exp_q.pop_front();
                end else if (!in_frame && |{bus.data_valid, bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en,
                                            bus.stop_chk_en, bus.deser_en, bus.edge_cnt, bus.bit_cnt}) begin
                    stray++;
                end
                if (in_frame && bus.busy) begin
                    if (!bogus) begin
                        a4 = {bus.strt_chk_en, bus.deser_en, bus.par_chk_en, bus.stop_chk_en};
                        if (int'(bus.edge_cnt) != c % cur.p || int'(bus.bit_cnt) != exp_bitcnt(cur, c) ||
                            a4 != exp_pulse(cur, c) || !bus.dat_samp_en || bus.data_valid) begin
                            if (bad == 0)
                                first_bad = $sformatf("c=%0d edge=%0d bit=%0d pulses=%b samp=%b dv=%b",
                                                      c, bus.edge_cnt, bus.bit_cnt, a4, bus.dat_samp_en, bus.data_valid);
                            bad++;
                        end
                        nd += int'(bus.deser_en);
                        np += int'(bus.par_chk_en);
                        ns += int'(bus.stop_chk_en);
                    end
                    c++;
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    if (!bogus) begin
                        chk("frame_len", c, cur.len);
                        chk("data_valid", int'(bus.data_valid), int'(cur.valid));
                        chk("deser_pulses", nd, cur.n_deser);
                        chk("par_pulses", np, cur.n_par);
                        chk("stop_pulses", ns, cur.n_stop);
                        chk("trace_deviations", bad, 0);
                        if (bad != 0) $display("  first trace deviation (P=%0d): %s", cur.p, first_bad);
                    end
                    if (bus.data_valid) valid_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send_frame(input int p, input bit pe, input logic [7:0] data, input bit g,
                              input bit perr, input bit serr, input int gap);
        exp_t        m;
        logic [10:0] fb;
        m  = model(p, pe, g, perr, serr);
        fb = {1'b1, pe ? 1'($urandom) : 1'b1, data, 1'b0};
        repeat (gap) begin
            @(negedge clk);
            bus.rx_in = 1'b1;
        end
        @(negedge clk);
        bus.rx_in       = 1'b0;
        bus.prescale    = 6'(p);
        bus.par_en      = pe;
        bus.strt_glitch = g;
        bus.par_err     = perr;
        bus.stop_err    = serr;
        exp_q.push_back(m);
        for (int c = 0; c < m.len; c++) begin
            @(negedge clk);
            bus.rx_in = (c == m.len - 1) ? 1'b1 : g ? 1'(c >= 2) : fb[c / p];
            if (c == m.len / 2) bus.prescale = (p == 8) ? 6'd16 : 6'd8;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 1000) begin
            @(negedge clk);
            bus.rx_in = 1'b1;
            n++;
        end
        @(negedge clk);
        bus.rx_in = 1'b1;
        chk("drain", int'(exp_q.size() != 0 || in_frame), 0);
    endtask

    function automatic int all_outputs();
        return int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en, bus.par_chk_en,
                     bus.stop_chk_en, bus.deser_en, bus.data_valid, bus.busy});
    endfunction

    initial begin
        int p;
        bus.rx_in       = 1'b1;
        bus.par_en      = 1'b0;
        bus.prescale    = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stop_err    = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1);
        wait_idle();
        send_frame(16, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1);
        wait_idle();
        send_frame(16, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1);
        wait_idle();
        send_frame(32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1);
        wait_idle();

        valid_cyc.delete();
        send_frame(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        wait_idle();
        chk("b2b_valid_count", valid_cyc.size(), 2);
        chk("b2b_spacing", valid_cyc.size() == 2 ? valid_cyc[1] - valid_cyc[0] : -1, 81);

        @(negedge clk);
        bus.rx_in       = 1'b0;
        bus.prescale    = 6'd8;
        bus.par_en      = 1'b0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stop_err    = 1'b0;
        exp_q.push_back(model(8, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (8 + 4 * 8 + 3) begin
            @(negedge clk);
            bus.rx_in = 1'($urandom);
        end
        bus.rx_in = 1'b1;
        chk("pre_rst_bit_cnt", int'(bus.bit_cnt), 4);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst_outputs", all_outputs(), 0);
        chk("rst_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(16, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            do p = $urandom_range(8, 32); while (!is_legal_prescale(p));
            send_frame(p, 1'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
        end
        wait_idle();
        chk("stray_idle_outputs", stray, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
